// File: rtl/uc_rr_arbiter_if.sv
// Unit-clause arbiter bus: memory and engine literal sources, broadcast output and status.
`default_nettype none

interface uc_rr_arbiter_if #(
  parameter int NUM_ENG    = 4,
  parameter int LIT_W      = 8,
  parameter int FIFO_DEPTH = 8
) ();

  logic                           clear;
  logic                           input_mode;
  logic                           mem_valid;
  logic [LIT_W-1:0]               mem_lit;
  logic                           mem_ready;
  logic [NUM_ENG-1:0]             eng_valid;
  logic [NUM_ENG*LIT_W-1:0]       eng_lit;
  logic [NUM_ENG-1:0]             eng_pop;
  logic                           out_valid;
  logic [LIT_W-1:0]               out_lit;
  logic                           out_ready;
  logic                           conflict;
  logic [LIT_W-1:0]               conflict_lit;
  logic [$clog2(FIFO_DEPTH):0]    fifo_count;

  modport master (
    output clear, input_mode, mem_valid, mem_lit, eng_valid, eng_lit, out_ready,
    input  mem_ready, eng_pop, out_valid, out_lit, conflict, conflict_lit, fifo_count
  );

  modport slave (
    input  clear, input_mode, mem_valid, mem_lit, eng_valid, eng_lit, out_ready,
    output mem_ready, eng_pop, out_valid, out_lit, conflict, conflict_lit, fifo_count
  );

endinterface

`default_nettype wire

// File: rtl/uc_rr_arbiter.sv
// Unit-clause arbiter: memory/engine literal selection, variable-table conflict check, broadcast FIFO.
// Optional build macro UCA_DEDUP_EN drops same-polarity repeat literals instead of re-broadcasting them.
`default_nettype none

module uc_rr_arbiter #(
  parameter int NUM_ENG    = 4,
  parameter int LIT_W      = 8,
  parameter int NUM_VAR    = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  uc_rr_arbiter_if.slave    bus
);

  localparam int ENG_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int SUM_W  = ENG_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int VIDX_W = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;

`ifdef UCA_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic [ENG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        count_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic                    conflict_q;
  logic [LIT_W-1:0]        conflict_lit_q;
  logic [NUM_VAR-1:0]      assigned_q;
  logic [NUM_VAR-1:0]      pol_q;
  logic [LIT_W-1:0]        fifo_q [FIFO_DEPTH];

  logic                    w_accept_en;
  logic                    w_mem_take;
  logic                    w_eng_take;
  logic                    w_take;
  logic [2*NUM_ENG-1:0]    w_dbl;
  logic [NUM_ENG-1:0]      w_rot;
  logic [ENG_W-1:0]        w_fp_idx;
  logic [ENG_W-1:0]        w_rr_off;
  logic [SUM_W-1:0]        w_rr_sum;
  logic [ENG_W-1:0]        w_rr_idx;
  logic [ENG_W-1:0]        w_grant;
  logic [SUM_W-1:0]        w_nxt_sum;
  logic [ENG_W-1:0]        w_nxt_ptr;
  logic [LIT_W-1:0]        w_lit;
  logic                    w_sign;
  logic [LIT_W-1:0]        w_mag;
  logic                    w_in_range;
  logic [VIDX_W-1:0]       w_idx;
  logic                    w_hit;
  logic                    w_same;
  logic                    w_set;
  logic                    w_conf;
  logic                    w_dup;
  logic                    w_push;
  logic                    w_pop;

  // Accept gating uses the registered count so a same-cycle pop never frees space.
  assign w_accept_en = rst & ~bus.clear & ~conflict_q & (count_q < CNT_W'(FIFO_DEPTH));
  assign w_mem_take  = w_accept_en & bus.mem_valid;
  assign w_eng_take  = w_accept_en & ~bus.mem_valid & (|bus.eng_valid);
  assign w_take      = w_mem_take | w_eng_take;

  // Rotating the doubled request vector puts rr_ptr at bit 0.
  assign w_dbl = {bus.eng_valid, bus.eng_valid};
  assign w_rot = w_dbl[rr_ptr_q +: NUM_ENG];

  always_comb begin
    w_fp_idx = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (bus.eng_valid[i]) w_fp_idx = ENG_W'(i);
    end
    w_rr_off = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (w_rot[i]) w_rr_off = ENG_W'(i);
    end
  end

  assign w_rr_sum  = {1'b0, rr_ptr_q} + {1'b0, w_rr_off};
  assign w_rr_idx  = (w_rr_sum >= SUM_W'(NUM_ENG)) ? ENG_W'(w_rr_sum - SUM_W'(NUM_ENG))
                                                    : ENG_W'(w_rr_sum);
  assign w_grant   = bus.input_mode ? w_rr_idx : w_fp_idx;
  assign w_nxt_sum = {1'b0, w_grant} + SUM_W'(1);
  assign w_nxt_ptr = (w_nxt_sum >= SUM_W'(NUM_ENG)) ? ENG_W'(w_nxt_sum - SUM_W'(NUM_ENG))
                                                     : ENG_W'(w_nxt_sum);
  assign rr_ptr_d  = (w_eng_take & bus.input_mode) ? w_nxt_ptr : rr_ptr_q;

  assign bus.mem_ready = w_mem_take;
  assign bus.eng_pop   = w_eng_take ? (NUM_ENG'(1) << w_grant) : '0;

  assign w_lit      = w_mem_take ? bus.mem_lit : bus.eng_lit[w_grant*LIT_W +: LIT_W];
  assign w_sign     = w_lit[LIT_W-1];
  assign w_mag      = w_sign ? (~w_lit + LIT_W'(1)) : w_lit;
  assign w_in_range = (w_mag != '0) && (32'(w_mag) < 32'(NUM_VAR));
  assign w_idx      = w_mag[VIDX_W-1:0];
  assign w_hit      = assigned_q[w_idx];
  assign w_same     = (pol_q[w_idx] == w_sign);

  // Zero or out-of-range literals are consumed with none of these firing.
  assign w_set  = w_take & w_in_range & ~w_hit;
  assign w_conf = w_take & w_in_range & w_hit & ~w_same;
  assign w_dup  = w_take & w_in_range & w_hit & w_same;
  assign w_push = w_set | (w_dup & ~DEDUP);
  assign w_pop  = (count_q != '0) & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q       <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
      assigned_q     <= '0;
      pol_q          <= '0;
    end else if (bus.clear) begin
      rr_ptr_q       <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
      assigned_q     <= '0;
      pol_q          <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (w_set) begin
        assigned_q[w_idx] <= 1'b1;
        pol_q[w_idx]      <= w_sign;
      end
      if (w_conf) begin
        conflict_q     <= 1'b1;
        conflict_lit_q <= w_lit;
      end
    end
  end

  // Storage needs no reset: out_valid is qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) fifo_q[wr_ptr_q] <= w_lit;
  end

  assign bus.out_valid    = (count_q != '0);
  assign bus.out_lit      = fifo_q[rd_ptr_q];
  assign bus.fifo_count   = count_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_lit = conflict_lit_q;

endmodule

`default_nettype wire

// File: tb/tb_uc_rr_arbiter.sv
// Directed scenario bench for uc_rr_arbiter with an output-order scoreboard.
`default_nettype none

module tb_uc_rr_arbiter;

  localparam int NE = 4;
  localparam int LW = 8;
  localparam int FD = 8;

`ifdef UCA_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  typedef struct packed {
    logic        mode;
    logic [3:0]  valid;
    logic [31:0] lits;
    logic [3:0]  pop;
    logic [7:0]  lit;
  } rr_row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [LW-1:0] sb [$];
  logic [LW-1:0] mon_exp;

  always #5 clk = ~clk;

  uc_rr_arbiter_if #(.NUM_ENG(NE), .LIT_W(LW), .FIFO_DEPTH(FD)) bus ();

  uc_rr_arbiter #(.NUM_ENG(NE), .LIT_W(LW), .NUM_VAR(64), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Broadcast monitor: every transfer must match the oldest expected literal.
  always begin
    @(negedge clk);
    #3;
    if (rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL out_lit_unexpected: got %0d, expected no output", $signed(bus.out_lit));
      end else begin
        mon_exp = sb.pop_front();
        if (bus.out_lit !== mon_exp) begin
          failures++;
          $display("FAIL out_lit_order: got %0d, expected %0d", $signed(bus.out_lit), $signed(mon_exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.clear     = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_lit   = '0;
    bus.eng_valid = '0;
    bus.eng_lit   = '0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    idle();
    bus.out_ready = 1'b0;
    bus.clear     = 1'b1;
    @(negedge clk);
    bus.clear     = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    idle();
    bus.out_ready = 1'b1;
    while (n < 60) begin
      @(negedge clk);
      #4;
      if (sb.size() == 0 && !bus.out_valid) break;
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d out_valid=%0b, expected 0 and 0", sb.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    idle();
    bus.input_mode = 1'b0;
    bus.out_ready  = 1'b0;
    #1 rst = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_lit   = 8'd5;
    bus.eng_valid = 4'hF;
    repeat (2) @(negedge clk);
    #2;
    checks += 6;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.fifo_count !== 4'd0) begin failures++; $display("FAIL rst_fifo_count: got %0d, expected 0", bus.fifo_count); end
    if (bus.conflict !== 1'b0) begin failures++; $display("FAIL rst_conflict: got %b, expected 0", bus.conflict); end
    if (bus.conflict_lit !== 8'd0) begin failures++; $display("FAIL rst_conflict_lit: got %0d, expected 0", bus.conflict_lit); end
    if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL rst_mem_ready: got %b, expected 0", bus.mem_ready); end
    if (bus.eng_pop !== 4'b0000) begin failures++; $display("FAIL rst_eng_pop: got %b, expected 0000", bus.eng_pop); end
    @(negedge clk);
    idle();
    rst = 1'b1;
  endtask

  task automatic test_rr();
    rr_row_t rows [10];
    rows[0] = '{1'b1, 4'hF, 32'h04030201, 4'b0001, 8'd1};
    rows[1] = '{1'b1, 4'hF, 32'h04030201, 4'b0010, 8'd2};
    rows[2] = '{1'b1, 4'hF, 32'h04030201, 4'b0100, 8'd3};
    rows[3] = '{1'b1, 4'hF, 32'h04030201, 4'b1000, 8'd4};
    rows[4] = '{1'b1, 4'h5, 32'h00160014, 4'b0001, 8'd20};
    rows[5] = '{1'b1, 4'h5, 32'h00160015, 4'b0100, 8'd22};
    rows[6] = '{1'b1, 4'h3, 32'h00001817, 4'b0001, 8'd23};
    rows[7] = '{1'b0, 4'h8, 32'h19000000, 4'b1000, 8'd25};
    rows[8] = '{1'b0, 4'hA, 32'h1F001E00, 4'b0010, 8'd30};
    rows[9] = '{1'b1, 4'hF, 32'h1D1C1B1A, 4'b0010, 8'd27};
    do_clear();
    bus.out_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      bus.input_mode = rows[r].mode;
      bus.eng_valid  = rows[r].valid;
      bus.eng_lit    = rows[r].lits;
      #2;
      checks++;
      if (bus.eng_pop !== rows[r].pop || bus.mem_ready !== 1'b0) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got eng_pop=%b mem_ready=%b, expected %b and 0", r, bus.eng_pop, bus.mem_ready, rows[r].pop);
      end
      sb.push_back(rows[r].lit);
    end
    drain();
  endtask

  task automatic test_mem_priority();
    do_clear();
    bus.out_ready  = 1'b1;
    bus.input_mode = 1'b0;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_lit   = 8'd5;
    bus.eng_valid = 4'b0001;
    bus.eng_lit   = 32'h00000006;
    #2;
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.eng_pop !== 4'b0000) begin
      failures++;
      $display("FAIL mem_priority: got mem_ready=%b eng_pop=%b, expected 1 and 0000", bus.mem_ready, bus.eng_pop);
    end
    sb.push_back(8'd5);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    #2;
    checks++;
    if (bus.mem_ready !== 1'b0 || bus.eng_pop !== 4'b0001) begin
      failures++;
      $display("FAIL eng_after_mem: got mem_ready=%b eng_pop=%b, expected 0 and 0001", bus.mem_ready, bus.eng_pop);
    end
    sb.push_back(8'd6);
    drain();
  endtask

  task automatic test_discard();
    logic [7:0] bad [5];
    bad = '{8'd0, 8'd64, 8'h9C, 8'hC0, 8'd127};
    do_clear();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_lit   = bad[k];
      #2;
      checks++;
      if (bus.mem_ready !== 1'b1) begin
        failures++;
        $display("FAIL discard_ready[%0d]: got %b, expected 1", k, bus.mem_ready);
      end
    end
    @(negedge clk);
    bus.mem_lit = 8'd63;
    #2;
    checks++;
    if (bus.fifo_count !== 4'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL discard_count: got fifo_count=%0d out_valid=%b, expected 0 and 0", bus.fifo_count, bus.out_valid);
    end
    sb.push_back(8'd63);
    @(negedge clk);
    idle();
    #2;
    checks++;
    if (bus.fifo_count !== 4'd1) begin
      failures++;
      $display("FAIL max_var_push: got fifo_count=%0d, expected 1", bus.fifo_count);
    end
    drain();
  endtask

  task automatic test_conflict();
    do_clear();
    bus.input_mode = 1'b0;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_lit   = 8'd7;
    #2;
    sb.push_back(8'd7);
    @(negedge clk);
    bus.mem_lit = 8'hF9;
    #2;
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_accept: got mem_ready=%b conflict=%b, expected 1 and 0", bus.mem_ready, bus.conflict);
    end
    @(negedge clk);
    bus.mem_lit   = 8'd8;
    bus.eng_valid = 4'b0001;
    bus.eng_lit   = 32'h00000009;
    #2;
    checks += 3;
    if (bus.conflict !== 1'b1 || bus.conflict_lit !== 8'hF9) begin
      failures++;
      $display("FAIL conflict_flag: got conflict=%b lit=%0d, expected 1 and -7", bus.conflict, $signed(bus.conflict_lit));
    end
    if (bus.mem_ready !== 1'b0 || bus.eng_pop !== 4'b0000) begin
      failures++;
      $display("FAIL conflict_block: got mem_ready=%b eng_pop=%b, expected 0 and 0000", bus.mem_ready, bus.eng_pop);
    end
    if (bus.fifo_count !== 4'd1) begin
      failures++;
      $display("FAIL conflict_count: got fifo_count=%0d, expected 1", bus.fifo_count);
    end
    drain();
    checks++;
    if (bus.conflict !== 1'b1) begin
      failures++;
      $display("FAIL conflict_sticky: got %b, expected 1", bus.conflict);
    end
    do_clear();
    #2;
    checks++;
    if (bus.conflict !== 1'b0 || bus.conflict_lit !== 8'd0) begin
      failures++;
      $display("FAIL clear_conflict: got conflict=%b lit=%0d, expected 0 and 0", bus.conflict, bus.conflict_lit);
    end
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_lit   = 8'hF9;
    #2;
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_after_clear: got %b, expected 1", bus.mem_ready);
    end
    sb.push_back(8'hF9);
    drain();
  endtask

  task automatic test_dup();
    do_clear();
    bus.input_mode = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.eng_valid = 4'b0001;
      bus.eng_lit   = 32'h00000003;
      #2;
      checks++;
      if (bus.eng_pop !== 4'b0001) begin
        failures++;
        $display("FAIL dup_pop[%0d]: got %b, expected 0001", k, bus.eng_pop);
      end
      if (k == 0 || !DEDUP) sb.push_back(8'd3);
    end
    @(negedge clk);
    idle();
    #2;
    checks++;
    if (bus.fifo_count !== (DEDUP ? 4'd1 : 4'd2) || bus.conflict !== 1'b0) begin
      failures++;
      $display("FAIL dup_count: got fifo_count=%0d conflict=%b, expected %0d and 0", bus.fifo_count, bus.conflict, DEDUP ? 1 : 2);
    end
    drain();
  endtask

  task automatic test_full();
    do_clear();
    bus.input_mode = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.eng_valid = 4'b0001;
      bus.eng_lit   = {24'd0, 8'(k)};
      #2;
      checks++;
      if (bus.eng_pop !== 4'b0001) begin
        failures++;
        $display("FAIL full_fill[%0d]: got eng_pop=%b, expected 0001", k, bus.eng_pop);
      end
      sb.push_back(8'(k));
    end
    @(negedge clk);
    bus.eng_lit = 32'h00000009;
    #2;
    checks++;
    if (bus.fifo_count !== 4'd8 || bus.eng_pop !== 4'b0000) begin
      failures++;
      $display("FAIL full_block: got fifo_count=%0d eng_pop=%b, expected 8 and 0000", bus.fifo_count, bus.eng_pop);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #2;
    checks++;
    if (bus.eng_pop !== 4'b0000) begin
      failures++;
      $display("FAIL full_same_cycle_pop: got eng_pop=%b, expected 0000", bus.eng_pop);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #2;
    checks++;
    if (bus.fifo_count !== 4'd7 || bus.eng_pop !== 4'b0001) begin
      failures++;
      $display("FAIL full_refill: got fifo_count=%0d eng_pop=%b, expected 7 and 0001", bus.fifo_count, bus.eng_pop);
    end
    sb.push_back(8'd9);
    @(negedge clk);
    idle();
    #2;
    checks++;
    if (bus.fifo_count !== 4'd8) begin
      failures++;
      $display("FAIL full_recount: got fifo_count=%0d, expected 8", bus.fifo_count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [7:0] pre [3];
    pre = '{8'hFF, 8'd2, 8'd3};
    do_clear();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_lit   = pre[k];
    end
    @(negedge clk);
    idle();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fifo_count !== 4'd0) begin
      failures++;
      $display("FAIL midreset_flush: got out_valid=%b fifo_count=%0d, expected 0 and 0", bus.out_valid, bus.fifo_count);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_lit   = 8'd1;
    #2;
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_accept: got mem_ready=%b, expected 1", bus.mem_ready);
    end
    sb.push_back(8'd1);
    @(negedge clk);
    idle();
    #2;
    checks++;
    if (bus.conflict !== 1'b0 || bus.fifo_count !== 4'd1) begin
      failures++;
      $display("FAIL midreset_stale: got conflict=%b fifo_count=%0d, expected 0 and 1", bus.conflict, bus.fifo_count);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_rr();
    test_mem_priority();
    test_discard();
    test_conflict();
    test_dup();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
